rs_issue_arb: RTL and testbench
===============================

RS_ISSUE_ARB -- requirements
Module: rs_issue_arb

Interface
REQ-001 SHALL have parameter RS_SIZE, default 16: number of reservation-station entries.
REQ-002 SHALL have parameter MULT_LAT, default 4: multiplier occupancy in cycles per op (2..15).
REQ-003 SHALL have port clock  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: reset is synchronous and active-low.
REQ-005 SHALL have port enable  input  1: issue permitted this cycle when 1.
REQ-006 SHALL have port squash_signal_in  input  1: pipeline flush.
REQ-007 SHALL have port ready  input  RS_SIZE: entry i has all operands and is valid.
REQ-008 SHALL have port fu_type  input  2*RS_SIZE: entry i FU class at bits [2i+1:2i]; 00 ALU, 01 MULT, 10 MEM, 11 BRANCH.
REQ-009 SHALL have port free  output  RS_SIZE: one-hot-or-two-hot grant; RS clears granted entries at the same edge.
REQ-010 SHALL have port issue_valid  output  2: issue slot k carries a grant.
REQ-011 SHALL have port issue_idx  output  2*$clog2(RS_SIZE): entry index per slot; slot k at bits [k*W+W-1:k*W].
REQ-012 SHALL have port mult_busy  output  1: multiplier cannot accept an op this cycle.

Function
REQ-013 SHALL compute grants combinationally from ready, fu_type and registered state (zero-cycle latency).
REQ-014 SHALL keep a registered round-robin pointer rr_ptr; the search order is rr_ptr, rr_ptr+1, ... wrapping modulo RS_SIZE.
REQ-015 Slot 0 SHALL take the first eligible entry in search order; slot 1 SHALL take the next eligible entry after slot 0's.
REQ-016 Eligibility: ready=1; MULT only if mult_busy=0; at most one MULT, one MEM and one BRANCH granted per cycle; up to two ALU.
REQ-017 Slot 1 SHALL NOT be valid unless slot 0 is valid; issue_idx of an invalid slot SHALL be 0.
REQ-018 free SHALL equal the OR of the one-hot encodings of the valid slots.
REQ-019 With enable=0 or squash_signal_in=1, free, issue_valid SHALL be 0.
REQ-020 On any grant, rr_ptr SHALL become (highest-order granted index in search order + 1) mod RS_SIZE; otherwise rr_ptr SHALL hold.
REQ-021 A 4-bit mult_cnt SHALL load MULT_LAT-1 when a MULT is granted; otherwise it SHALL decrement when nonzero, regardless of enable.
REQ-022 mult_busy SHALL equal (mult_cnt != 0).
REQ-023 squash_signal_in=1 SHALL clear mult_cnt to 0 and rr_ptr to 0 at the next edge; squash takes priority over all other updates.
REQ-024 A MULT granted the cycle mult_cnt reaches 0 from 1 SHALL NOT occur; eligibility uses the current registered mult_cnt only.

Reset
REQ-025 While reset=0 at a rising edge, rr_ptr and mult_cnt SHALL become 0.
REQ-026 During reset and until the first non-reset edge, free=0, issue_valid=0, issue_idx=0, mult_busy=0.
REQ-027 Reset asserted mid-multiply SHALL abandon the occupancy; mult_busy=0 the cycle after reset.

Configuration
REQ-028 Macro MULT_PIPELINED_EN, when defined, SHALL model a fully pipelined multiplier: mult_cnt removed, mult_busy tied 0, one MULT eligible every cycle.
REQ-029 Without MULT_PIPELINED_EN, REQ-021..REQ-024 SHALL apply unchanged.

Verification
REQ-030 Reset, then ready=16'hFFFF, all ALU, enable=1 -> free=16'h0003, issue_idx={1,0}; next cycle rr_ptr=2, free=16'h000C.
REQ-031 ready=16'h0006, fu_type entries 1,2 = MULT, MULT_LAT=4 -> cycle0 grants entry 1 only; mult_busy=1 for 3 cycles; entry 2 granted in cycle 4.
REQ-032 rr_ptr=15, ready=16'h8001, both ALU -> issue_idx slot0=15, slot1=0, free=16'h8001; rr_ptr becomes 1.
REQ-033 ready=16'h0030, both MEM -> only entry 4 granted; entry 5 granted next cycle.
REQ-034 MULT granted, then squash_signal_in=1 next cycle with ready=16'hFFFF -> free=0 that cycle; next cycle mult_busy=0, rr_ptr=0, free=16'h0003.
REQ-035 enable=0 for 3 cycles after MULT grant with MULT_LAT=4 -> mult_busy falls at the same cycle as with enable=1; no grants while enable=0.

Source files
------------

// File: rtl/rs_issue_arb.sv
// rs_issue_arb: dual-slot issue arbiter for a reservation station with round-robin
// priority and multiplier occupancy tracking; define MULT_PIPELINED_EN for a pipelined multiplier.
module rs_issue_arb #(
  parameter int RS_SIZE  = 16,
  parameter int MULT_LAT = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         squash_signal_in,
  input  logic [RS_SIZE-1:0]           ready,
  input  logic [2*RS_SIZE-1:0]         fu_type,
  output logic [RS_SIZE-1:0]           free,
  output logic [1:0]                   issue_valid,
  output logic [2*$clog2(RS_SIZE)-1:0] issue_idx,
  output logic                         mult_busy
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam logic [1:0] FU_ALU  = 2'b00;
  localparam logic [1:0] FU_MULT = 2'b01;
  localparam logic [1:0] FU_MEM  = 2'b10;
  localparam logic [1:0] FU_BR   = 2'b11;
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RS_SIZE - 1);

  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] rr_ptr_nxt_s;
  logic [IDX_W-1:0] slot0_idx_s;
  logic [IDX_W-1:0] slot1_idx_s;
  logic [IDX_W-1:0] cand_s;
  logic [1:0]       slot_vld_s;
  logic [1:0]       ftype_s;
  logic             took_mult_s;
  logic             took_mem_s;
  logic             took_br_s;
  logic             elig_s;
  logic             grant_mult_s;
  logic             mult_busy_s;
  int               pos_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == LAST_IDX) begin
      wrap_inc = IDX_ZERO;
    end else begin
      wrap_inc = idx + IDX_W'(1);
    end
  endfunction

  // Walk entries from rr_ptr in wrap order, filling slot 0 then slot 1 with eligible entries
  always_comb begin
    slot_vld_s  = 2'b00;
    slot0_idx_s = IDX_ZERO;
    slot1_idx_s = IDX_ZERO;
    took_mult_s = 1'b0;
    took_mem_s  = 1'b0;
    took_br_s   = 1'b0;
    pos_s       = 0;
    cand_s      = IDX_ZERO;
    ftype_s     = FU_ALU;
    elig_s      = 1'b0;
    if (reset && enable && !squash_signal_in) begin
      for (int k = 0; k < RS_SIZE; k++) begin
        pos_s = int'(rr_ptr_r) + k;
        if (pos_s >= RS_SIZE) begin
          pos_s = pos_s - RS_SIZE;
        end else begin
          pos_s = pos_s;
        end
        cand_s  = IDX_W'(pos_s);
        ftype_s = fu_type[{cand_s, 1'b0} +: 2];
        case (ftype_s)
          FU_ALU:  elig_s = 1'b1;
          FU_MULT: elig_s = !mult_busy_s && !took_mult_s;
          FU_MEM:  elig_s = !took_mem_s;
          FU_BR:   elig_s = !took_br_s;
          default: elig_s = 1'b0;
        endcase
        if (ready[cand_s] && elig_s && !slot_vld_s[1]) begin
          if (slot_vld_s[0]) begin
            slot_vld_s[1] = 1'b1;
            slot1_idx_s   = cand_s;
          end else begin
            slot_vld_s[0] = 1'b1;
            slot0_idx_s   = cand_s;
          end
          took_mult_s = took_mult_s | (ftype_s == FU_MULT);
          took_mem_s  = took_mem_s  | (ftype_s == FU_MEM);
          took_br_s   = took_br_s   | (ftype_s == FU_BR);
        end else begin
          slot_vld_s = slot_vld_s;
        end
      end
    end else begin
      slot_vld_s = 2'b00;
    end
  end

  assign grant_mult_s = took_mult_s;
  assign issue_valid  = slot_vld_s;
  assign issue_idx    = {slot1_idx_s, slot0_idx_s};
  assign free         = (slot_vld_s[0] ? (RS_SIZE'(1) << slot0_idx_s) : {RS_SIZE{1'b0}})
                      | (slot_vld_s[1] ? (RS_SIZE'(1) << slot1_idx_s) : {RS_SIZE{1'b0}});
  assign mult_busy    = mult_busy_s;

  // Pointer moves past the last entry granted in search order; squash rewinds it
  always_comb begin
    if (squash_signal_in) begin
      rr_ptr_nxt_s = IDX_ZERO;
    end else if (slot_vld_s[1]) begin
      rr_ptr_nxt_s = wrap_inc(slot1_idx_s);
    end else if (slot_vld_s[0]) begin
      rr_ptr_nxt_s = wrap_inc(slot0_idx_s);
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_r <= IDX_ZERO;
    end else begin
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

`ifdef MULT_PIPELINED_EN
  logic unused_grant_mult_s;
  assign unused_grant_mult_s = grant_mult_s;
  assign mult_busy_s         = 1'b0;
`else
  logic [3:0] mult_cnt_r;
  logic [3:0] mult_cnt_nxt_s;

  // Occupancy counter counts down independently of enable; squash abandons it
  always_comb begin
    if (squash_signal_in) begin
      mult_cnt_nxt_s = 4'd0;
    end else if (grant_mult_s) begin
      mult_cnt_nxt_s = 4'(MULT_LAT - 1);
    end else if (mult_cnt_r != 4'd0) begin
      mult_cnt_nxt_s = mult_cnt_r - 4'd1;
    end else begin
      mult_cnt_nxt_s = mult_cnt_r;
    end
  end

  // Multiplier occupancy register
  always_ff @(posedge clock) begin
    if (!reset) begin
      mult_cnt_r <= 4'd0;
    end else begin
      mult_cnt_r <= mult_cnt_nxt_s;
    end
  end

  // Gated by reset so busy reads 0 before the first reset edge has landed
  assign mult_busy_s = reset && (mult_cnt_r != 4'd0);
`endif

endmodule

// File: tb/tb_rs_issue_arb.sv
// tb_rs_issue_arb: directed checks of rs_issue_arb (RS_SIZE=16, MULT_LAT=4).
// Observed vector is {free, issue_valid, issue_idx(slot1,slot0), mult_busy}.
module tb_rs_issue_arb;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        squash_signal_in;
  logic [15:0] ready;
  logic [31:0] fu_type;
  logic [15:0] free;
  logic [1:0]  issue_valid;
  logic [7:0]  issue_idx;
  logic        mult_busy;
  logic [26:0] obs;
  logic [26:0] exp_v;
  int          n_total;
  int          n_pass;

  rs_issue_arb #(.RS_SIZE(16), .MULT_LAT(4)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .squash_signal_in(squash_signal_in),
    .ready(ready),
    .fu_type(fu_type),
    .free(free),
    .issue_valid(issue_valid),
    .issue_idx(issue_idx),
    .mult_busy(mult_busy)
  );

  assign obs = {free, issue_valid, issue_idx, mult_busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; squash_signal_in = 1'b0;
    ready = 16'h0000; fu_type = 32'h0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; squash_signal_in = 1'b0;
    ready = 16'hFFFF; fu_type = 32'h0;
    @(negedge clock);
    exp_v = {16'h0000, 2'b00, 8'h00, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL reset_pre_edge got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    @(negedge clock);
    n_total++; if (obs !== exp_v) $display("FAIL reset_held got %h want %h", obs, exp_v); else n_pass++;
    // MULT at entry 0, then reset in the middle of its occupancy
    next_cycle();
    reset = 1'b1; ready = 16'h0001; fu_type = 32'h0000_0001;
    @(negedge clock);
    exp_v = {16'h0001, 2'b01, 8'h00, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL reset_mult_grant got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    ready = 16'h0000;
    @(negedge clock);
    exp_v = {16'h0000, 2'b00, 8'h00, 1'b1};
    n_total++; if (obs !== exp_v) $display("FAIL reset_mult_busy got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    exp_v = {16'h0000, 2'b00, 8'h00, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL reset_mid_mult got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    n_total++; if (obs !== exp_v) $display("FAIL reset_abandon got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_alu_pair();
    do_reset();
    enable = 1'b1; ready = 16'hFFFF; fu_type = 32'h0;
    @(negedge clock);
    exp_v = {16'h0003, 2'b11, 8'h10, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL alu_c0 got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    ready = 16'hFFFC;
    @(negedge clock);
    exp_v = {16'h000C, 2'b11, 8'h32, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL alu_c1 got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    ready = 16'hFFF0;
    @(negedge clock);
    exp_v = {16'h0030, 2'b11, 8'h54, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL alu_c2 got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_mult();
    do_reset();
    enable = 1'b1; ready = 16'h0006; fu_type = 32'h0000_0014;
    @(negedge clock);
    exp_v = {16'h0002, 2'b01, 8'h01, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL mult_c0 got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    ready = 16'h0004;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      exp_v = {16'h0000, 2'b00, 8'h00, 1'b1};
      n_total++; if (obs !== exp_v) $display("FAIL mult_busy_c%0d got %h want %h", c, obs, exp_v); else n_pass++;
      next_cycle();
    end
    @(negedge clock);
    exp_v = {16'h0004, 2'b01, 8'h02, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL mult_c4 got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
  endtask

  task automatic test_wrap();
    do_reset();
    enable = 1'b1; ready = 16'h4000; fu_type = 32'h0;
    @(negedge clock);
    exp_v = {16'h4000, 2'b01, 8'h0E, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL wrap_setup got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    ready = 16'h8001;
    @(negedge clock);
    exp_v = {16'h8001, 2'b11, 8'h0F, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL wrap_grant got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    ready = 16'h0003;
    @(negedge clock);
    exp_v = {16'h0003, 2'b11, 8'h01, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL wrap_ptr1 got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_mem();
    do_reset();
    enable = 1'b1; ready = 16'h0030; fu_type = 32'h0000_0A00;
    @(negedge clock);
    exp_v = {16'h0010, 2'b01, 8'h04, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL mem_c0 got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    ready = 16'h0020;
    @(negedge clock);
    exp_v = {16'h0020, 2'b01, 8'h05, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL mem_c1 got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_mixed();
    do_reset();
    enable = 1'b1; ready = 16'h0007; fu_type = 32'h0000_000F;
    @(negedge clock);
    exp_v = {16'h0005, 2'b11, 8'h20, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL mix_branch got %h want %h", obs, exp_v); else n_pass++;
    do_reset();
    enable = 1'b1; ready = 16'h0007; fu_type = 32'h0000_0005;
    @(negedge clock);
    exp_v = {16'h0005, 2'b11, 8'h20, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL mix_mult got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    ready = 16'h0002;
    @(negedge clock);
    exp_v = {16'h0000, 2'b00, 8'h00, 1'b1};
    n_total++; if (obs !== exp_v) $display("FAIL mix_busy_block got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_squash();
    do_reset();
    enable = 1'b1; ready = 16'h0008; fu_type = 32'h0000_0040;
    @(negedge clock);
    exp_v = {16'h0008, 2'b01, 8'h03, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL squash_grant got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    squash_signal_in = 1'b1; ready = 16'hFFFF; fu_type = 32'h0;
    @(negedge clock);
    exp_v = {16'h0000, 2'b00, 8'h00, 1'b1};
    n_total++; if (obs !== exp_v) $display("FAIL squash_cycle got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    squash_signal_in = 1'b0;
    @(negedge clock);
    exp_v = {16'h0003, 2'b11, 8'h10, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL squash_after got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b1; ready = 16'h0001; fu_type = 32'h0000_0001;
    @(negedge clock);
    exp_v = {16'h0001, 2'b01, 8'h00, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL en_grant got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
    enable = 1'b0; ready = 16'h0002;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      exp_v = {16'h0000, 2'b00, 8'h00, 1'b1};
      n_total++; if (obs !== exp_v) $display("FAIL en_off_c%0d got %h want %h", c, obs, exp_v); else n_pass++;
      next_cycle();
    end
    enable = 1'b1;
    @(negedge clock);
    exp_v = {16'h0002, 2'b01, 8'h01, 1'b0};
    n_total++; if (obs !== exp_v) $display("FAIL en_resume got %h want %h", obs, exp_v); else n_pass++;
    next_cycle();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b0; enable = 1'b0; squash_signal_in = 1'b0;
    ready = 16'h0000; fu_type = 32'h0;
    #1;
    test_reset();
    test_alu_pair();
    test_mult();
    test_wrap();
    test_mem();
    test_mixed();
    test_squash();
    test_enable();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
